color_sequencer: RTL and testbench
==================================

Name: color_sequencer

Overview:
Parametrised colour-index generator for the display path. It steps a colour code through the range [MIN_COLOR, MAX_COLOR]. Supported modes are up-wrap, down-wrap, ping-pong and hold. Each colour is held for a programmable dwell of (dwell+1) enabled cycles. Downstream pixel/LED logic consumes `color`, plus the `step` and `wrap` strobes for frame sync.

Parameters:
- COLOR_W, 4, width of colour code.
- MIN_COLOR, 2, lowest colour in sequence.
- MAX_COLOR, 5, highest colour in sequence.
  - Constraint: MIN_COLOR <= MAX_COLOR <= 2**COLOR_W-1.
- DWELL_W, 8, width of dwell counter/input.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  advance enable; 0 freezes all state.
- mode  in  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 hold.
- dwell  in  DWELL_W  enabled cycles per colour minus 1.
- load  in  1  load colour request.
- load_color  in  COLOR_W  colour to load.
- color  out  COLOR_W  current colour (registered).
- step  out  1  1-cycle pulse, asserted in the cycle `color` takes a new value through sequencing.
- wrap  out  1  1-cycle pulse marking completion of a sequence cycle.

Behaviour:
- The interface is clocked on clk; reset rst is synchronous, active-high; clock clk.
- Reset values:
  - color=MIN_COLOR
  - dwell_cnt=0
  - dir=up
  - step=0
  - wrap=0
- Priority per edge is rst > load > en.
- Load:
  - color <= load_color, clamped: values below MIN give MIN, values above MAX give MAX.
  - dwell_cnt <= 0, dir <= up.
  - step=0 and wrap=0 in the following cycle.
- en=0: color, dwell_cnt and dir hold; step=wrap=0.
- en=1, mode!=11:
  - If dwell_cnt >= dwell, that is a step event: dwell_cnt <= 0 and color advances. Otherwise dwell_cnt <= dwell_cnt+1.
  - The `>=` compare means that lowering dwell below the current count forces a step on the next enabled cycle.
  - dwell=0 steps every enabled cycle.
  - Colour changes every (dwell+1) enabled cycles. Latency from the enable edge to the new colour is 0 cycles: the new colour is registered at that edge.
- Advance rules on a step event:
  - Up: color+1. At MAX, color goes to MIN and wrap pulses.
  - Down: color-1. At MIN, color goes to MAX and wrap pulses.
  - Ping-pong going up: at MAX, dir goes down and color goes to MAX-1.
  - Ping-pong going down: at MIN, dir goes up, color goes to MIN+1, and wrap pulses.
  - Ping-pong never repeats an endpoint colour.
- Hold mode (11): color frozen, dwell_cnt <= 0, no step/wrap. dir is retained.
- Mode change mid-dwell: dwell_cnt is not reset. The new mode applies at the next step event.
  - Leaving ping-pong for up/down ignores dir.
  - Entering ping-pong uses the stored dir.
- Degenerate range MIN==MAX: color is constant. Each step event pulses step and wrap.
  - In ping-pong, dir toggles but color is unchanged.
- MAX==MIN+1 in ping-pong: color alternates; wrap pulses on every arrival at MIN+1 from MIN.
- step and wrap are registered pulses, high for exactly one cycle per event.
- Arithmetic is done in COLOR_W+1 bits to avoid overflow when MAX = 2**COLOR_W-1. color never leaves [MIN, MAX].

Decomposition:
- Package color_seq_pkg holds:
  - mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11;
  - direction constants DIR_UP/DIR_DOWN.
- Sub-module dwell_timer (parameter DWELL_W) takes clk, rst, en, clear, dwell and outputs tick.
  - tick is combinational, high when en && dwell_cnt >= dwell.
  - clear is driven by load or hold mode.
- The top level holds the colour/direction register and the next-colour logic.

Test Plan:
- Reset and defaults: rst=1 for 2 cycles, then en=1, mode=00, dwell=0.
  - Required: color sequence 2,3,4,5,2,3.
  - Required: step high every cycle; wrap high only in the cycle color becomes 2.
- Dwell: mode=00, dwell=2.
  - Required: each colour held 3 cycles (2,2,2,3,3,3,...).
  - Dropping en for 4 cycles mid-dwell extends that colour by exactly 4 cycles.
- Ping-pong: mode=10, dwell=0 from reset.
  - Required: 2,3,4,5,4,3,2,3.
  - Required: wrap only when 3 follows 2 after the descent; no wrap at 5.
- Down plus load:
  - mode=01 gives 5,4,3,2,5 with wrap when 5 follows 2.
  - load=1 with load_color=9 gives color=5 next cycle, no step.
  - load_color=0 gives color=2.
  - load and rst together: rst wins, color=2.
- Hold and mode switch:
  - mode=11 at color=4 for 10 cycles: color stays 4, no step.
  - Switching to mode=00 with dwell=1 gives the next colour 5 after 2 cycles.
- Degenerate range (MIN_COLOR=MAX_COLOR=7, COLOR_W=3), any mode with dwell=0:
  - Required: color=7 constant, with step and wrap every cycle.
  - Required: no overflow at the maximum code.

Source files
------------

// File: rtl/color_sequencer_pkg.sv
// Shared encodings for the colour sequencer: mode codes and the ping-pong direction.
package color_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/color_sequencer_if.sv
// Control/status bundle between the display controller and the colour sequencer.
interface color_sequencer_if #(
  parameter int COLOR_W = 4,
  parameter int DWELL_W = 8
);

  logic               en;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic               load;
  logic [COLOR_W-1:0] load_color;
  logic [COLOR_W-1:0] color;
  logic               step;
  logic               wrap;

  modport master (
    output en, mode, dwell, load, load_color,
    input  color, step, wrap
  );

  modport slave (
    input  en, mode, dwell, load, load_color,
    output color, step, wrap
  );

endinterface

// File: rtl/color_sequencer_dwell_timer.sv
// Counts enabled cycles spent on the current colour; tick flags the cycle that ends the dwell.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] dwellCnt_q;
  logic [DWELL_W-1:0] dwellCnt_d;

  // >= rather than == so that shrinking dwell below the count steps immediately
  assign tick = en && (dwellCnt_q >= dwell);

  always_comb begin
    dwellCnt_d = dwellCnt_q;
    if (clear) begin
      dwellCnt_d = '0;
    end else if (tick) begin
      dwellCnt_d = '0;
    end else if (en) begin
      dwellCnt_d = dwellCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwellCnt_q <= '0;
    end else begin
      dwellCnt_q <= dwellCnt_d;
    end
  end

endmodule

// File: rtl/color_sequencer.sv
// Colour-index generator: walks color through [MIN_COLOR, MAX_COLOR] in up, down,
// ping-pong or hold mode, emitting registered step/wrap strobes for frame sync.
module color_sequencer
  import color_seq_pkg::*;
#(
  parameter int COLOR_W   = 4,
  parameter int MIN_COLOR = 2,
  parameter int MAX_COLOR = 5,
  parameter int DWELL_W   = 8
) (
  input logic               clk,
  input logic               rst,
  color_sequencer_if.slave  bus
);

  // One extra bit keeps +1 safe when MAX_COLOR is the largest code
  localparam logic [COLOR_W:0] MinX       = (COLOR_W+1)'(MIN_COLOR);
  localparam logic [COLOR_W:0] MaxX       = (COLOR_W+1)'(MAX_COLOR);
  localparam logic             Degenerate = (MIN_COLOR == MAX_COLOR);

  logic [COLOR_W-1:0] color_q, color_d;
  dir_e               dir_q, dir_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;

  logic               holdMode;
  logic               clear;
  logic               tick;
  logic               stepEvent;
  logic [COLOR_W:0]   colorX;
  logic [COLOR_W:0]   loadX;
  logic [COLOR_W:0]   nextX;

  assign holdMode  = (mode_e'(bus.mode) == MODE_HOLD);
  assign clear     = bus.load | (bus.en & holdMode);
  assign stepEvent = tick & ~bus.load & ~holdMode;
  assign colorX    = {1'b0, color_q};
  assign loadX     = {1'b0, bus.load_color};

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .clear (clear),
    .dwell (bus.dwell),
    .tick  (tick)
  );

  always_comb begin
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    nextX  = colorX;
    if (bus.load) begin
      if (loadX < MinX) begin
        nextX = MinX;
      end else if (loadX > MaxX) begin
        nextX = MaxX;
      end else begin
        nextX = loadX;
      end
      dir_d = DIR_UP;
    end else if (stepEvent) begin
      step_d = 1'b1;
      case (mode_e'(bus.mode))
        MODE_UP: begin
          if (colorX >= MaxX) begin
            nextX  = MinX;
            wrap_d = 1'b1;
          end else begin
            nextX = colorX + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (colorX <= MinX) begin
            nextX  = MaxX;
            wrap_d = 1'b1;
          end else begin
            nextX = colorX - 1'b1;
          end
        end
        MODE_PINGPONG: begin
          // A single-colour range only flips direction; every turn counts as a wrap
          if (dir_q == DIR_UP) begin
            if (colorX >= MaxX) begin
              dir_d  = DIR_DOWN;
              nextX  = Degenerate ? MaxX : MaxX - 1'b1;
              wrap_d = Degenerate;
            end else begin
              nextX = colorX + 1'b1;
            end
          end else begin
            if (colorX <= MinX) begin
              dir_d  = DIR_UP;
              nextX  = Degenerate ? MinX : MinX + 1'b1;
              wrap_d = 1'b1;
            end else begin
              nextX = colorX - 1'b1;
            end
          end
        end
        default: begin
          nextX = colorX;
        end
      endcase
    end
    color_d = nextX[COLOR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      color_q <= MinX[COLOR_W-1:0];
      dir_q   <= DIR_UP;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      color_q <= color_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.color = color_q;
  assign bus.step  = step_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer: a 2..5 instance for the main modes and a 7..7 instance
// for the single-colour range.
module tb_color_sequencer;
  import color_seq_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  color_sequencer_if #(.COLOR_W(4), .DWELL_W(8)) busA ();
  color_sequencer_if #(.COLOR_W(3), .DWELL_W(8)) busB ();

  color_sequencer #(
    .COLOR_W(4), .MIN_COLOR(2), .MAX_COLOR(5), .DWELL_W(8)
  ) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  color_sequencer #(
    .COLOR_W(3), .MIN_COLOR(7), .MAX_COLOR(7), .DWELL_W(8)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic enV, input logic [1:0] modeV, input logic [7:0] dwellV,
                               input logic loadV, input logic [3:0] lcV);
    busA.en         = enV;
    busA.mode       = modeV;
    busA.dwell      = dwellV;
    busA.load       = loadV;
    busA.load_color = lcV;
  endtask

  // Advance one clock, then check instance A a little after the edge
  task automatic expectA(input string tag, input int c, input logic s, input logic w);
    @(posedge clk);
    #1;
    checkOutput({tag, " color"}, 8'(busA.color), 8'(c));
    checkOutput({tag, " step"},  8'(busA.step),  8'(s));
    checkOutput({tag, " wrap"},  8'(busA.wrap),  8'(w));
  endtask

  task automatic expectB(input string tag, input int c, input logic s, input logic w);
    @(posedge clk);
    #1;
    checkOutput({tag, " color"}, 8'(busB.color), 8'(c));
    checkOutput({tag, " step"},  8'(busB.step),  8'(s));
    checkOutput({tag, " wrap"},  8'(busB.wrap),  8'(w));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    applyStimulus(1'b0, MODE_UP, 8'd0, 1'b0, 4'd0);
    busB.en         = 1'b0;
    busB.mode       = MODE_UP;
    busB.dwell      = 8'd0;
    busB.load       = 1'b0;
    busB.load_color = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset color", 8'(busA.color), 8'd2);
    checkOutput("reset step",  8'(busA.step),  8'd0);
    checkOutput("reset wrap",  8'(busA.wrap),  8'd0);
    checkOutput("reset colorB", 8'(busB.color), 8'd7);

    $display("[TB] up-wrap, dwell 0");
    rst = 1'b0;
    applyStimulus(1'b1, MODE_UP, 8'd0, 1'b0, 4'd0);
    expectA("up", 3, 1, 0);
    expectA("up", 4, 1, 0);
    expectA("up", 5, 1, 0);
    expectA("up", 2, 1, 1);
    expectA("up", 3, 1, 0);

    $display("[TB] up-wrap, dwell 2 with enable gap");
    rst = 1'b1;
    expectA("rst", 2, 0, 0);
    rst = 1'b0;
    applyStimulus(1'b1, MODE_UP, 8'd2, 1'b0, 4'd0);
    expectA("dwell", 2, 0, 0);
    expectA("dwell", 2, 0, 0);
    expectA("dwell", 3, 1, 0);
    expectA("dwell", 3, 0, 0);
    applyStimulus(1'b0, MODE_UP, 8'd2, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) expectA("en off", 3, 0, 0);
    applyStimulus(1'b1, MODE_UP, 8'd2, 1'b0, 4'd0);
    expectA("dwell resume", 3, 0, 0);
    expectA("dwell resume", 4, 1, 0);

    $display("[TB] ping-pong");
    rst = 1'b1;
    expectA("rst", 2, 0, 0);
    rst = 1'b0;
    applyStimulus(1'b1, MODE_PINGPONG, 8'd0, 1'b0, 4'd0);
    expectA("pp", 3, 1, 0);
    expectA("pp", 4, 1, 0);
    expectA("pp", 5, 1, 0);
    expectA("pp", 4, 1, 0);
    expectA("pp", 3, 1, 0);
    expectA("pp", 2, 1, 0);
    expectA("pp", 3, 1, 1);
    expectA("pp", 4, 1, 0);

    $display("[TB] down-wrap and load");
    rst = 1'b1;
    expectA("rst", 2, 0, 0);
    rst = 1'b0;
    applyStimulus(1'b1, MODE_DOWN, 8'd0, 1'b1, 4'd9);
    expectA("load high", 5, 0, 0);
    applyStimulus(1'b1, MODE_DOWN, 8'd0, 1'b0, 4'd0);
    expectA("down", 4, 1, 0);
    expectA("down", 3, 1, 0);
    expectA("down", 2, 1, 0);
    expectA("down", 5, 1, 1);
    expectA("down", 4, 1, 0);
    applyStimulus(1'b1, MODE_DOWN, 8'd0, 1'b1, 4'd0);
    expectA("load low", 2, 0, 0);
    applyStimulus(1'b1, MODE_DOWN, 8'd0, 1'b1, 4'd3);
    expectA("load mid", 3, 0, 0);
    rst = 1'b1;
    applyStimulus(1'b1, MODE_DOWN, 8'd0, 1'b1, 4'd4);
    expectA("rst over load", 2, 0, 0);
    rst = 1'b0;

    $display("[TB] hold and mode switch");
    applyStimulus(1'b1, MODE_DOWN, 8'd0, 1'b1, 4'd4);
    expectA("load 4", 4, 0, 0);
    applyStimulus(1'b1, MODE_HOLD, 8'd0, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) expectA("hold", 4, 0, 0);
    applyStimulus(1'b1, MODE_UP, 8'd1, 1'b0, 4'd0);
    expectA("after hold", 4, 0, 0);
    expectA("after hold", 5, 1, 0);
    expectA("after hold", 5, 0, 0);
    expectA("after hold", 2, 1, 1);
    applyStimulus(1'b1, MODE_UP, 8'd5, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) expectA("long dwell", 2, 0, 0);
    applyStimulus(1'b1, MODE_UP, 8'd1, 1'b0, 4'd0);
    expectA("dwell lowered", 3, 1, 0);

    $display("[TB] single-colour range");
    applyStimulus(1'b0, MODE_UP, 8'd0, 1'b0, 4'd0);
    busB.en = 1'b1;
    busB.mode = MODE_UP;
    expectB("deg up", 7, 1, 1);
    expectB("deg up", 7, 1, 1);
    busB.mode = MODE_PINGPONG;
    expectB("deg pp", 7, 1, 1);
    expectB("deg pp", 7, 1, 1);
    expectB("deg pp", 7, 1, 1);
    busB.mode = MODE_DOWN;
    expectB("deg down", 7, 1, 1);
    expectB("deg down", 7, 1, 1);
    busB.load = 1'b1;
    busB.load_color = 3'd0;
    expectB("deg load", 7, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
